// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, return-address stack, sync-read ROM
// interface and a one-deep fetch pipeline that squashes the in-flight word on
// every taken redirect.
module fetch_unit #(
    parameter  int PC_W  = 10,
    parameter  int DEPTH = 8,
    localparam int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_en,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     inst,
    output logic            inst_valid,
    output logic [PC_W-1:0] inst_pc,
    input  logic            jump_taken,
    input  logic            call,
    input  logic            ret,
    input  logic [PC_W-1:0] jump_target,
    output logic [SP_W-1:0] stack_depth,
    output logic            stack_ovf,
    output logic            stack_unf
);

    // Stack index width; a single-entry stack still needs one address bit.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  inst_pc_q;
    logic             valid_q;
    logic [SP_W-1:0]  sp;
    logic             ovf_q;
    logic             unf_q;
    logic [PC_W-1:0]  stack_mem [DEPTH];

    logic             redirect;
    logic             do_call;
    logic             do_ret;
    logic             stack_full;
    logic             stack_empty;
    logic [IDX_W-1:0] top_idx;
    logic [PC_W-1:0]  ret_target;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  push_data;

    // Redirect decode: only a live, non-stalled instruction may steer the PC.
    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        redirect    = 1'b0;
        do_call     = 1'b0;
        do_ret      = 1'b0;
        stack_full  = (sp == SP_W'(DEPTH));
        stack_empty = (sp == '0);
        top_idx     = IDX_W'(sp - SP_W'(1));
        ret_target  = '0;
        target      = jump_target;
        push_data   = inst_pc_q + PC_W'(1);

        redirect = valid_q & ~stall & (jump_taken | call | ret);
        do_ret   = redirect & ret;
        do_call  = redirect & ~ret & call;

        if (!stack_empty) begin
            ret_target = stack_mem[top_idx];
        end
        if (ret) begin
            target = ret_target;
        end
    end

    // PC, fetch pipeline, stack pointer and sticky error flags.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            sp        <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else if (!stall) begin
            if (redirect) begin
                pc      <= target;
                valid_q <= 1'b0;
                if (do_call) begin
                    if (stack_full) ovf_q <= 1'b1;
                    else            sp    <= sp + SP_W'(1);
                end
                if (do_ret) begin
                    if (stack_empty) unf_q <= 1'b1;
                    else             sp    <= sp - SP_W'(1);
                end
            end else begin
                inst_pc_q <= pc;
                valid_q   <= 1'b1;
                pc        <= pc + PC_W'(1);
            end
        end
    end

    // Return-address storage written on a successful push.
    // NOTE: the stack array is deliberately not reset; its contents are only
    // read below sp, and sp itself is reset.
    always_ff @(posedge clk) begin
        if (!rst && do_call && !stack_full) begin
            stack_mem[IDX_W'(sp)] <= push_data;
        end
    end

    assign imem_addr   = pc;
    assign imem_en     = ~stall;
    assign inst        = imem_rdata;
    assign inst_valid  = valid_q;
    assign inst_pc     = inst_pc_q;
    assign stack_depth = sp;
    assign stack_ovf   = ovf_q;
    assign stack_unf   = unf_q;

endmodule
